// File: rtl/fp_pkg.sv
// Shared floating-point conversion definitions: fflags bit positions,
// IEEE-754 double exponent constants and the writeback entry record.
package fp_pkg;

  // fflags bit positions {NV,DZ,OF,UF,NX}
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  // Double-precision exponent constants
  localparam int          DP_BIAS    = 1023;
  localparam logic [10:0] DP_EXP_MAX = 11'h7FF;

  // First biased exponent whose magnitude no longer fits in 32 unsigned bits (2^32)
  localparam int DP_EXP_U32_OVF = DP_BIAS + 32;

  // Width of the destination index held in an entry; RD_W of users must not exceed it
  localparam int FP_RD_W = 5;

  // One writeback entry: destination, 32-bit result, derived flags
  typedef struct packed {
    logic [FP_RD_W-1:0] rd;
    logic [31:0]        wu;
    logic [4:0]         flags;
  } fp_entry_t;

endpackage

// File: rtl/fp_cvt_wu_wb_if.sv
// Handshake bundle between the double->uword converter, the writeback stage
// and the integer register file. slave = the writeback stage, master = its
// surroundings (converter on the input side, regfile on the output side).
interface fp_cvt_wu_wb_if #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_d;
  logic [31:0]     in_wu;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [RD_W-1:0] out_rd;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_flags;

  modport slave (
    input  in_valid, in_d, in_wu, in_rd, out_ready,
    output in_ready, out_valid, out_rd, out_data, out_flags
  );

  modport master (
    output in_valid, in_d, in_wu, in_rd, out_ready,
    input  in_ready, out_valid, out_rd, out_data, out_flags
  );
endinterface

// File: rtl/fp_cvt_wu_flags.sv
// Exception flag derivation for a double -> unsigned 32-bit conversion with
// round-toward-zero. Purely combinational; shared with the signed-word stage.
module fp_cvt_wu_flags
  import fp_pkg::*;
(
  input  logic [63:0] i_d,
  output logic        o_nv,
  output logic        o_nx
);

  logic        w_sign;
  logic [10:0] w_exp;
  logic [51:0] w_man;
  logic [10:0] w_unb_exp;
  logic [51:0] w_frac_mask;

  assign w_sign = i_d[63];
  assign w_exp  = i_d[62:52];
  assign w_man  = i_d[51:0];

  // Invalid when the value is NaN/Inf, negative with magnitude >= 1, or >= 2^32;
  // otherwise inexact when any bit below the binary point is set.
  always_comb begin
    w_unb_exp   = w_exp - 11'(DP_BIAS);
    // Only evaluated for 0 <= e < 32, so the low 5 bits are the full shift;
    // the mask keeps the low 52-e mantissa bits, i.e. the fractional part.
    w_frac_mask = {52{1'b1}} >> w_unb_exp[4:0];
    o_nv = (w_exp == DP_EXP_MAX)
         | (w_sign  & (w_exp >= 11'(DP_BIAS)))
         | (!w_sign & (w_exp >= 11'(DP_EXP_U32_OVF)));
    o_nx = 1'b0;
    if (!o_nv) begin
      if (w_exp < 11'(DP_BIAS)) begin
        o_nx = |{w_exp, w_man};
      end else begin
        o_nx = |(w_man & w_frac_mask);
      end
    end
  end

endmodule

// File: rtl/fp_cvt_wu_wb.sv
// Writeback stage for FCVT.WU.D: registers the converter result with its
// derived NV/NX flags behind a 2-entry skid buffer (A presents, S absorbs
// back-pressure), sign-extends to XLEN and accumulates sticky fflags.
// Optional: define FP_CVT_NAN_FIX_EN to force the result of any NaN operand
// to 0xFFFFFFFF (canonical RISC-V result, including negative NaN).
module fp_cvt_wu_wb
  import fp_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  fp_cvt_wu_wb_if.slave       bus,
  input  logic                flush,
  input  logic                csr_we,
  input  logic [4:0]          csr_wdata,
  output logic [4:0]          fflags
);

  logic      w_nv;
  logic      w_nx;
  logic      w_accept;
  logic      w_fire;
  fp_entry_t w_in_ent;

  fp_entry_t r_a;
  fp_entry_t r_s;
  logic      r_a_vld;
  logic      r_s_vld;
  logic      r_in_ready;
  logic [4:0] r_fflags;

  fp_cvt_wu_flags u_flags (
    .i_d  (bus.in_d),
    .o_nv (w_nv),
    .o_nx (w_nx)
  );

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_fire   = r_a_vld & bus.out_ready;

  // Build the entry captured from the converter this cycle
  always_comb begin
    w_in_ent         = '0;
    w_in_ent.rd      = FP_RD_W'(bus.in_rd);
`ifdef FP_CVT_NAN_FIX_EN
    if ((bus.in_d[62:52] == DP_EXP_MAX) && (bus.in_d[51:0] != 52'd0)) begin
      w_in_ent.wu = 32'hFFFF_FFFF;
    end else begin
      w_in_ent.wu = bus.in_wu;
    end
`else
    w_in_ent.wu      = bus.in_wu;
`endif
    w_in_ent.flags[FLG_NV] = w_nv;
    w_in_ent.flags[FLG_NX] = w_nx;
  end

  // Skid control and presenting entry A; ready is registered as !(S valid next)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_a_vld    <= 1'b0;
      r_s_vld    <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_a_vld    <= 1'b0;
      r_s_vld    <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (!r_a_vld || w_fire) begin
      if (r_s_vld) begin
        // S advances into A; a new input (if any) refills S
        r_a        <= r_s;
        r_a_vld    <= 1'b1;
        r_s_vld    <= w_accept;
        r_in_ready <= !w_accept;
      end else begin
        if (w_accept) begin
          r_a <= w_in_ent;
        end
        r_a_vld    <= w_accept;
        r_s_vld    <= 1'b0;
        r_in_ready <= 1'b1;
      end
    end else begin
      // A is stalled: any accepted input parks in S
      r_s_vld    <= r_s_vld | w_accept;
      r_in_ready <= !(r_s_vld | w_accept);
    end
  end

  // Skid entry data: every accepted input is written here; its valid bit
  // decides whether it is meaningful, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s <= w_in_ent;
    end
  end

  // Sticky fflags: a retiring entry's flags are ORed on top of any CSR write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fflags <= 5'b0;
    end else begin
      r_fflags <= (csr_we ? csr_wdata : r_fflags) | (w_fire ? r_a.flags : 5'b0);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_a_vld;
  assign bus.out_rd    = RD_W'(r_a.rd);
  assign bus.out_flags = r_a.flags;
  assign fflags        = r_fflags;

  generate
    if (XLEN > 32) begin : g_sext
      assign bus.out_data = {{(XLEN-32){r_a.wu[31]}}, r_a.wu};
    end else begin : g_nosext
      assign bus.out_data = r_a.wu[XLEN-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_fp_cvt_wu_wb.sv
// Bench for fp_cvt_wu_wb: directed cases followed by random traffic, all
// checked against a queue-based reference model of the writeback stage.
module tb_fp_cvt_wu_wb;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [4:0]  flags;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       csr_we = 1'b0;
  logic [4:0] csr_wdata = 5'd0;
  logic [4:0] fflags;

  exp_t       q[$];
  logic [4:0] fired_rd[$];
  logic [4:0] ff_m;
  int         checks = 0;
  int         errors = 0;
  int         rdv;
  logic       accepted;

  fp_cvt_wu_wb_if #(.XLEN(64), .RD_W(5)) bus();

  fp_cvt_wu_wb #(.XLEN(64), .RD_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flush     (flush),
    .csr_we    (csr_we),
    .csr_wdata (csr_wdata),
    .fflags    (fflags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flags from the conversion rules, using arithmetic on the value fields
  function automatic logic [4:0] ref_flags(input logic [63:0] d);
    int unsigned     ex = d[62:52];
    longint unsigned mn = d[51:0];
    bit              neg = d[63];
    bit              nv;
    bit              nx;
    int              e;
    nv = (ex == 2047) || (neg && ex >= 1023) || (!neg && ex >= 1055);
    nx = 1'b0;
    if (!nv) begin
      if (ex < 1023) begin
        nx = (ex != 0) || (mn != 0);
      end else begin
        e  = int'(ex) - 1023;
        nx = (mn % (64'd1 << (52 - e))) != 0;
      end
    end
    return {nv, 3'b000, nx};
  endfunction

  function automatic logic [63:0] ref_data(input logic [63:0] d, input logic [31:0] w);
    logic [31:0] r = w;
    longint      v;
`ifdef FP_CVT_NAN_FIX_EN
    if (d[62:52] == 11'h7FF && d[51:0] != 52'd0) r = 32'hFFFF_FFFF;
`endif
    v = $signed(r);
    return v;
  endfunction

  function automatic logic [63:0] rand_d();
    logic [63:0] raw = {$urandom, $urandom};
    logic [10:0] ex;
    logic [51:0] mn;
    int          k = $urandom_range(0, 5);
    int          z = $urandom_range(0, 52);
    case (k)
      0:       ex = 11'd0;
      1:       ex = 11'h7FF;
      2, 3:    ex = 11'($urandom_range(1015, 1060));
      default: ex = raw[62:52];
    endcase
    mn = raw[51:0];
    mn = (mn >> z) << z;
    return {raw[63], ex, mn};
  endfunction

  task automatic send(input logic v, input logic [63:0] d, input logic [31:0] w, input logic [4:0] rd);
    bus.in_valid = v;
    bus.in_d     = d;
    bus.in_wu    = w;
    bus.in_rd    = rd;
  endtask

  // One clock: advance the model alongside the DUT, then check all outputs
  task automatic cycle();
    bit   acc;
    bit   fire;
    exp_t e;
    acc     = bus.in_valid && (q.size() < 2);
    fire    = (q.size() > 0) && bus.out_ready;
    e.rd    = bus.in_rd;
    e.data  = ref_data(bus.in_d, bus.in_wu);
    e.flags = ref_flags(bus.in_d);
    if (bus.out_valid && bus.out_ready) fired_rd.push_back(bus.out_rd);
    @(posedge clk);
    if (fire) begin
      ff_m = (csr_we ? csr_wdata : ff_m) | q[0].flags;
      void'(q.pop_front());
    end else if (csr_we) begin
      ff_m = csr_wdata;
    end
    if (flush) q.delete();
    else if (acc) q.push_back(e);
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("fflags", 64'(fflags), 64'(ff_m));
    if (q.size() > 0) begin
      chk("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
      chk("out_data", bus.out_data, q[0].data);
      chk("out_flags", 64'(bus.out_flags), 64'(q[0].flags));
    end
  endtask

  initial begin
    send(1'b0, 64'd0, 32'd0, 5'd0);
    bus.out_ready = 1'b0;
    ff_m = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
    chk("rst_out_flags", 64'(bus.out_flags), 64'd0);
    chk("rst_fflags", 64'(fflags), 64'd0);
    rst = 1'b0;

    // 3.7 -> 3, inexact
    bus.out_ready = 1'b1;
    send(1'b1, 64'h400D99999999999A, 32'd3, 5'd1);
    cycle();
    send(1'b0, 64'd0, 32'd0, 5'd0);
    chk("t1_data", bus.out_data, 64'h3);
    chk("t1_flags", 64'(bus.out_flags), 64'h01);
    cycle();
    chk("t1_fflags", 64'(fflags), 64'h01);

    // 2^32 -> invalid, all-ones sign-extended
    send(1'b1, 64'h41F0000000000000, 32'hFFFF_FFFF, 5'd2);
    cycle();
    send(1'b0, 64'd0, 32'd0, 5'd0);
    chk("t2_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_flags", 64'(bus.out_flags), 64'h10);
    cycle();

    // -0.5 inexact, -2.0 invalid
    send(1'b1, 64'hBFE0000000000000, 32'd0, 5'd3);
    cycle();
    chk("t3a_data", bus.out_data, 64'd0);
    chk("t3a_flags", 64'(bus.out_flags), 64'h01);
    send(1'b1, 64'hC000000000000000, 32'd0, 5'd4);
    cycle();
    chk("t3b_flags", 64'(bus.out_flags), 64'h10);
    send(1'b0, 64'd0, 32'd0, 5'd0);
    cycle();

    // Negative NaN
    send(1'b1, 64'hFFF8000000000000, 32'd0, 5'd5);
    cycle();
    send(1'b0, 64'd0, 32'd0, 5'd0);
    chk("t4_flags", 64'(bus.out_flags), 64'h10);
`ifdef FP_CVT_NAN_FIX_EN
    chk("t4_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("t4_data", bus.out_data, 64'd0);
`endif
    cycle();

    // Back-pressure: two accepts then stall, release preserves order
    bus.out_ready = 1'b0;
    fired_rd.delete();
    rdv = 1;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 64'h400D99999999999A, 32'd3, 5'(rdv));
      accepted = bus.in_ready;
      cycle();
      if (accepted) rdv++;
    end
    chk("t5_accepts", 64'(rdv), 64'd3);
    chk("t5_stall_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12 && rdv <= 4; i++) begin
      send(1'b1, 64'h400D99999999999A, 32'd3, 5'(rdv));
      accepted = bus.in_ready;
      cycle();
      if (accepted) rdv++;
    end
    send(1'b0, 64'd0, 32'd0, 5'd0);
    repeat (4) cycle();
    chk("t5_count", 64'(fired_rd.size()), 64'd4);
    for (int i = 0; i < fired_rd.size(); i++) chk("t5_order", 64'(fired_rd[i]), 64'(i + 1));

    // CSR write coinciding with a retiring entry, then flush with two held
    csr_we = 1'b1; csr_wdata = 5'h11;
    cycle();
    csr_we = 1'b0;
    chk("t6_csr", 64'(fflags), 64'h11);
    bus.out_ready = 1'b0;
    send(1'b1, 64'h400D99999999999A, 32'd3, 5'd6);
    cycle();
    send(1'b0, 64'd0, 32'd0, 5'd0);
    bus.out_ready = 1'b1;
    csr_we = 1'b1; csr_wdata = 5'h00;
    cycle();
    csr_we = 1'b0;
    chk("t6_sticky", 64'(fflags), 64'h01);
    bus.out_ready = 1'b0;
    send(1'b1, 64'hC000000000000000, 32'd0, 5'd7);
    cycle();
    send(1'b1, 64'hBFE0000000000000, 32'd0, 5'd8);
    cycle();
    send(1'b0, 64'd0, 32'd0, 5'd0);
    chk("t6_held", 64'(bus.out_valid), 64'd1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t6_flush_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_flush_ready", 64'(bus.in_ready), 64'd1);
    chk("t6_flush_fflags", 64'(fflags), 64'h01);

    // Asynchronous reset in the middle of traffic
    csr_we = 1'b1; csr_wdata = 5'h1F;
    send(1'b1, 64'h400D99999999999A, 32'd3, 5'd9);
    cycle();
    csr_we = 1'b0;
    send(1'b1, 64'h41F0000000000000, 32'hFFFF_FFFF, 5'd10);
    cycle();
    send(1'b0, 64'd0, 32'd0, 5'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_fflags", 64'(fflags), 64'd0);
    q.delete();
    ff_m = 5'd0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      send(($urandom_range(0, 3) != 0), rand_d(), $urandom, 5'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 31) == 0);
      csr_we        = ($urandom_range(0, 15) == 0);
      csr_wdata     = 5'($urandom);
      cycle();
    end
    send(1'b0, 64'd0, 32'd0, 5'd0);
    flush = 1'b0;
    csr_we = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
